parameter_fifo_packer: RTL and testbench

Parametrised successor to the single-chip MICROROC parameter generator. It snapshots either the slow-control or the read-scope parameter vectors for a daisy chain of CHIP_NUM chips and packs them into WORD_WIDTH-bit words, MSB first. The words go into the external FIFO that feeds the slow-clock bit shifter. Unlike the fixed single-chip version, it honours FIFO back-pressure, writes one word per clock, zero-pads a partial last word, and supports abort.

---
 rtl/parameter_fifo_packer.sv | 140 ++++++++++++++
 tb/tb_parameter_fifo_packer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parameter_fifo_packer.sv
// parameter_fifo_packer
// Snapshots the slow-control or read-scope parameter vectors of a chip daisy
// chain, left-aligns them in a shift register and streams them MSB first into
// an external FIFO one word per clock. It waits while the FIFO is full, zero-pads
// the last word and can be aborted.
//
// The read-scope vector shares the slow-control-sized shift register, so
// RS_WIDTH must not exceed SC_WIDTH.
module parameter_fifo_packer #(
    parameter int SC_WIDTH   = 592,
    parameter int RS_WIDTH   = 64,
    parameter int CHIP_NUM   = 1,
    parameter int WORD_WIDTH = 16,
    localparam int SC_TOTAL  = CHIP_NUM * SC_WIDTH,
    localparam int RS_TOTAL  = CHIP_NUM * RS_WIDTH,
    localparam int NSC       = (SC_TOTAL + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int WC_W      = $clog2(NSC + 1)
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  ParameterLoadStart,
    input  logic                  ParameterLoadAbort,
    input  logic                  SlowControlOrReadScopeSelect,
    input  logic [SC_TOTAL-1:0]   SlowControlParameters,
    input  logic [RS_TOTAL-1:0]   ReadScopeParameters,
    input  logic                  ExternalFifoFull,
    output logic                  ExternalFifoWriteEn,
    output logic [WORD_WIDTH-1:0] ExternalFifoData,
    output logic                  ParameterBusy,
    output logic                  ParameterDone,
    output logic [WC_W-1:0]       WordsWritten
);

    localparam int NRS    = (RS_TOTAL + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SR_W   = NSC * WORD_WIDTH;
    localparam int SC_PAD = SR_W - SC_TOTAL;
    localparam int RS_PAD = SR_W - RS_TOTAL;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [WC_W-1:0]   words_q, words_d;
    logic              busy_q, busy_d;

    logic [SR_W-1:0]   sc_aligned;
    logic [SR_W-1:0]   rs_aligned;
    logic [WC_W-1:0]   last_idx;
    logic              write_fire;

    // Left-align both vectors so padding lands only in the low bits of the last word
    assign sc_aligned = SR_W'(SlowControlParameters) << SC_PAD;
    assign rs_aligned = SR_W'(ReadScopeParameters) << RS_PAD;

    // Index of the final word for the latched mode
    assign last_idx   = mode_q ? WC_W'(NRS - 1) : WC_W'(NSC - 1);

    // A word is written only in WRITE; abort and full both win over the write
    assign write_fire = (state_q == S_WRITE) & ~ExternalFifoFull & ~ParameterLoadAbort;

    // State and datapath registers; asynchronous reset so a reset stops writes at once
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            shift_q <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            words_q <= words_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ParameterLoadStart) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = ParameterLoadAbort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (ParameterLoadAbort) begin
                    state_d = S_IDLE;
                end else if (write_fire && (words_q == last_idx)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: latch mode on start, snapshot in LOAD, shift on each write
    always_comb begin
        mode_d  = mode_q;
        shift_d = shift_q;
        words_d = words_q;
        if ((state_q == S_IDLE) && ParameterLoadStart) begin
            mode_d  = SlowControlOrReadScopeSelect;
            words_d = '0;
        end
        if ((state_q == S_LOAD) && !ParameterLoadAbort) begin
            shift_d = mode_q ? rs_aligned : sc_aligned;
        end
        if (write_fire) begin
            shift_d = shift_q << WORD_WIDTH;
            words_d = words_q + 1'b1;
        end
        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);
    end

    // Output decode
    always_comb begin
        ExternalFifoWriteEn = write_fire;
        ExternalFifoData    = shift_q[SR_W-1 -: WORD_WIDTH];
        ParameterBusy       = busy_q;
        ParameterDone       = (state_q == S_DONE);
        WordsWritten        = words_q;
    end

endmodule

// File: tb/tb_parameter_fifo_packer.sv
// Testbench for parameter_fifo_packer: three instances (default, 24-bit words,
// two chips) share control inputs; one is selected for observation per test.
// Expected FIFO words are queued at start and popped on every write strobe.
module tb_parameter_fifo_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, abort, sel_mode, full;

    logic [591:0]  sc0, sc1;
    logic [63:0]   rs0, rs1;
    logic [1183:0] sc2;
    logic [127:0]  rs2;

    logic        we0, we1, we2;
    logic [15:0] d0, d2;
    logic [23:0] d1;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [5:0]  w0;
    logic [4:0]  w1;
    logic [6:0]  w2;

    parameter_fifo_packer u_dut0 (
        .Clk(clk), .reset_n(reset_n), .ParameterLoadStart(start), .ParameterLoadAbort(abort),
        .SlowControlOrReadScopeSelect(sel_mode), .SlowControlParameters(sc0),
        .ReadScopeParameters(rs0), .ExternalFifoFull(full), .ExternalFifoWriteEn(we0),
        .ExternalFifoData(d0), .ParameterBusy(busy0), .ParameterDone(done0), .WordsWritten(w0)
    );

    parameter_fifo_packer #(.WORD_WIDTH(24)) u_dut1 (
        .Clk(clk), .reset_n(reset_n), .ParameterLoadStart(start), .ParameterLoadAbort(abort),
        .SlowControlOrReadScopeSelect(sel_mode), .SlowControlParameters(sc1),
        .ReadScopeParameters(rs1), .ExternalFifoFull(full), .ExternalFifoWriteEn(we1),
        .ExternalFifoData(d1), .ParameterBusy(busy1), .ParameterDone(done1), .WordsWritten(w1)
    );

    parameter_fifo_packer #(.CHIP_NUM(2)) u_dut2 (
        .Clk(clk), .reset_n(reset_n), .ParameterLoadStart(start), .ParameterLoadAbort(abort),
        .SlowControlOrReadScopeSelect(sel_mode), .SlowControlParameters(sc2),
        .ReadScopeParameters(rs2), .ExternalFifoFull(full), .ExternalFifoWriteEn(we2),
        .ExternalFifoData(d2), .ParameterBusy(busy2), .ParameterDone(done2), .WordsWritten(w2)
    );

    int          dut_sel;
    logic        mon_we, mon_busy, mon_done;
    logic [31:0] mon_data;
    logic [7:0]  mon_words;

    always_comb begin
        case (dut_sel)
            1: begin
                mon_we = we1; mon_data = 32'(d1); mon_busy = busy1;
                mon_done = done1; mon_words = 8'(w1);
            end
            2: begin
                mon_we = we2; mon_data = 32'(d2); mon_busy = busy2;
                mon_done = done2; mon_words = 8'(w2);
            end
            default: begin
                mon_we = we0; mon_data = 32'(d0); mon_busy = busy0;
                mon_done = done0; mon_words = 8'(w0);
            end
        endcase
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    // Reference packer: word i, bit j (MSB first) is vector bit t-1-(i*w+j), zero past the end
    function automatic logic [31:0] exp_word(input logic [1183:0] v, input int t, input int w, input int i);
        logic [31:0] r;
        int idx;
        r = '0;
        for (int j = 0; j < w; j++) begin
            idx = t - 1 - (i * w + j);
            if (idx >= 0) r[w-1-j] = v[idx];
        end
        return r;
    endfunction

    task automatic quiesce();
        @(negedge clk);
        start = 1'b0; full = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Runs one transfer on the selected instance and checks every cycle of it
    task automatic run_xfer(input string name, input int sel, input bit mode, input int n,
                            input bit use_full, input int abort_after, input bit keep_start,
                            input bit prefilled);
        logic [1183:0] rv;
        logic [31:0]   e, held;
        int            t, w, got, stalls, c;
        bit            ab, exp_we, exp_done, prev_stall, stall_now, finished;
        case (sel)
            1: begin w = 24; if (mode) begin rv = 1184'(rs1); t = 64; end else begin rv = 1184'(sc1); t = 592; end end
            2: begin w = 16; if (mode) begin rv = 1184'(rs2); t = 128; end else begin rv = sc2; t = 1184; end end
            default: begin w = 16; if (mode) begin rv = 1184'(rs0); t = 64; end else begin rv = 1184'(sc0); t = 592; end end
        endcase
        dut_sel = sel;
        if (!prefilled) begin
            sb_q.delete();
            for (int i = 0; i < n; i++) sb_q.push_back(exp_word(rv, t, w, i));
        end
        @(negedge clk);
        start = 1'b1; sel_mode = mode; reset_n = 1'b1;
        got = 0; stalls = 0; prev_stall = 1'b0; held = '0; finished = 1'b0;
        for (c = 1; c <= 400 && !finished; c++) begin
            @(negedge clk);
            if (!keep_start) start = 1'b0;
            if (c == 2 && sel == 0) sc0 = ~sc0;   // after LOAD: must not affect output
            full  = use_full && (c % 3 == 0);
            ab    = (abort_after >= 0) && (got == abort_after) && (c >= 2);
            abort = ab;
            #1;
            exp_we   = (c >= 2) && (got < n) && !full && !ab;
            exp_done = (abort_after < 0) && (c == n + 2 + stalls);
            n_cmp++;
            if (mon_we !== exp_we) begin
                n_err++; $display("FAIL %s strobe c=%0d got=%b want=%b", name, c, mon_we, exp_we);
            end
            n_cmp++;
            if (mon_words !== 8'(got)) begin
                n_err++; $display("FAIL %s words c=%0d got=%0d want=%0d", name, c, mon_words, got);
            end
            n_cmp++;
            if (mon_done !== exp_done || mon_busy !== !exp_done) begin
                n_err++; $display("FAIL %s done_busy c=%0d got=%b/%b want=%b/%b",
                                  name, c, mon_done, mon_busy, exp_done, !exp_done);
            end
            if (prev_stall) begin
                n_cmp++;
                if (mon_data !== held) begin
                    n_err++; $display("FAIL %s stall_hold c=%0d got=%h want=%h", name, c, mon_data, held);
                end
            end
            stall_now = (c >= 2) && (got < n) && full;
            if (mon_we) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL %s extra_word c=%0d got=%h want=none", name, c, mon_data);
                end else begin
                    e = sb_q.pop_front();
                    if (mon_data !== e) begin
                        n_err++; $display("FAIL %s word%0d got=%h want=%h", name, got, mon_data, e);
                    end
                end
                $display("[%0t] %s word %0d = %h", $time, name, got, mon_data);
                got++;
            end
            prev_stall = stall_now;
            held       = mon_data;
            if (stall_now) stalls++;
            if (ab) begin
                @(negedge clk);
                abort = 1'b0;
                #1;
                n_cmp++;
                if (mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_we !== 1'b0 || mon_words !== 8'(abort_after)) begin
                    n_err++; $display("FAIL %s after_abort got=busy%b done%b we%b words%0d want=0/0/0/%0d",
                                      name, mon_busy, mon_done, mon_we, mon_words, abort_after);
                end
                $display("[%0t] %s aborted after %0d words", $time, name, got);
                sb_q.delete();
                finished = 1'b1;
            end else if (exp_done) begin
                finished = 1'b1;
            end
        end
        if (!finished) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout got=%0d words want=%0d", name, got, n);
        end
        if (abort_after < 0) begin
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_err++; $display("FAIL %s missing_words got=%0d want=%0d", name, got, n);
            end
        end
        if (keep_start) begin
            // Start still high: one IDLE cycle, then a new LOAD that we abort
            @(negedge clk); #1;
            n_cmp++;
            if (mon_busy !== 1'b0 || mon_done !== 1'b0) begin
                n_err++; $display("FAIL %s idle_gap got=busy%b done%b want=0/0", name, mon_busy, mon_done);
            end
            @(negedge clk);
            start = 1'b0; abort = 1'b1;
            #1;
            n_cmp++;
            if (mon_busy !== 1'b1 || mon_we !== 1'b0 || mon_words !== 8'd0) begin
                n_err++; $display("FAIL %s restart_load got=busy%b we%b words%0d want=1/0/0",
                                  name, mon_busy, mon_we, mon_words);
            end
            @(negedge clk);
            abort = 1'b0;
            #1;
            n_cmp++;
            if (mon_busy !== 1'b0) begin
                n_err++; $display("FAIL %s load_abort got=busy%b want=0", name, mon_busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        dut_sel = 0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; full = 1'b0; sel_mode = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (mon_we !== 1'b0 || mon_data !== 32'd0 || mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_words !== 8'd0) begin
            n_err++; $display("FAIL reset got=we%b data%h busy%b done%b words%0d want=all zero",
                              mon_we, mon_data, mon_busy, mon_done, mon_words);
        end
        reset_n = 1'b1;
        $display("[%0t] reset released", $time);
    endtask

    task automatic test_sc_default();
        quiesce();
        run_xfer("sc16", 0, 1'b0, 37, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_rs_back_to_back();
        quiesce();
        sb_q.delete();
        sb_q.push_back(32'h0123); sb_q.push_back(32'h4567);
        sb_q.push_back(32'h89AB); sb_q.push_back(32'hCDEF);
        run_xfer("rs16", 0, 1'b1, 4, 1'b0, -1, 1'b1, 1'b1);
    endtask

    task automatic test_word24();
        quiesce();
        sb_q.delete();
        for (int i = 0; i < 24; i++) sb_q.push_back(32'hFFFFFF);
        sb_q.push_back(32'hFFFF00);
        run_xfer("sc24", 1, 1'b0, 25, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_chip2_backpressure();
        quiesce();
        run_xfer("sc2chip_full", 2, 1'b0, 74, 1'b1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        quiesce();
        run_xfer("sc16_abort", 0, 1'b0, 37, 1'b0, 10, 1'b0, 1'b0);
        run_xfer("sc16_after_abort", 0, 1'b0, 37, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        quiesce();
        dut_sel = 0;
        @(negedge clk);
        start = 1'b1; sel_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        n_cmp++;
        if (mon_we !== 1'b0 || mon_data !== 32'd0 || mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_words !== 8'd0) begin
            n_err++; $display("FAIL reset_mid got=we%b data%h busy%b done%b words%0d want=all zero",
                              mon_we, mon_data, mon_busy, mon_done, mon_words);
        end
        $display("[%0t] reset asserted mid-transfer", $time);
        run_xfer("sc16_after_reset", 0, 1'b0, 37, 1'b0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 592; i += 16) sc0[i +: 16] = 16'($urandom);
        for (int i = 0; i < 1184; i += 16) sc2[i +: 16] = 16'($urandom);
        sc1 = '1;
        rs0 = 64'h0123_4567_89AB_CDEF;
        rs1 = {32'($urandom), 32'($urandom)};
        rs2 = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        dut_sel = 0;
        test_reset();
        test_sc_default();
        test_rs_back_to_back();
        test_word24();
        test_chip2_backpressure();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
